// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: op encodings and multiply/divide FSM states shared by the execute stage.
package cpu_types_pkg;
   typedef enum logic [3:0] {
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_ADD, ALU_SUB, ALU_AND,
      ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
   } aluop_t;
   typedef enum logic [2:0] {MD_NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO} md_op_t;
   typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shift-add multiplier / restoring divider owning HI and LO.
// The divider is built only when EX_DIV_EN is defined; otherwise DIV/DIVU are ignored.
module muldiv_unit import cpu_types_pkg::*; #(
   parameter int WIDTH         = 32,
   parameter int MUL_STEP_BITS = 1
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             flush,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);
   localparam int W  = WIDTH;
   localparam int S  = MUL_STEP_BITS;
   localparam int CW = $clog2(WIDTH + 1);
   md_state_t state, state_n;
   logic [CW-1:0] count, last_count;
   logic [2*W-1:0] acc, acc_step, acc_ld, hl_n;
   logic [W-1:0] dvs, dvs_ld, a_mag, b_mag;
   logic [W+S-1:0] mul_sum;
   logic start, sgn, neg_lo;
   assign sgn   = op == MULT || op == DIV;
   assign a_mag = sgn && a[W-1] ? -a : a;
   assign b_mag = sgn && b[W-1] ? -b : b;
   // acc holds {partial product, unretired multiplier bits} or {remainder, dividend/quotient}
   assign mul_sum = {{S{1'b0}}, acc[2*W-1:W]} + (W+S)'(dvs) * (W+S)'(acc[S-1:0]);
`ifdef EX_DIV_EN
   logic is_div, neg_hi, dz, div_op;
   logic [W:0] diff;
   assign div_op     = op == DIV || op == DIVU;
   assign start      = op == MULT || op == MULTU || div_op;
   assign dvs_ld     = div_op ? b_mag : a_mag;
   assign acc_ld     = {{W{1'b0}}, div_op ? a_mag : b_mag};
   assign last_count = is_div ? CW'(W - 1) : CW'(W / S - 1);
   assign diff       = acc[2*W-1:W-1] - {1'b0, dvs};
   assign acc_step   = !is_div ? {mul_sum, acc[W-1:S]} :
                       diff[W] ? {acc[2*W-2:0], 1'b0} : {diff[W-1:0], acc[W-2:0], 1'b1};
   assign hl_n       = !is_div ? (neg_lo ? -acc_step : acc_step) :
                       {neg_hi ? -acc_step[2*W-1:W] : acc_step[2*W-1:W],
                        dz ? {W{1'b1}} : neg_lo ? -acc_step[W-1:0] : acc_step[W-1:0]};
   always_ff @(posedge CLK or negedge nRST)
      if (!nRST) {is_div, neg_hi, dz} <= '0;
      else if (state == MD_IDLE) {is_div, neg_hi, dz} <= {div_op, sgn && a[W-1], b == '0};
`else
   assign start      = op == MULT || op == MULTU;
   assign dvs_ld     = a_mag;
   assign acc_ld     = {{W{1'b0}}, b_mag};
   assign last_count = CW'(W / S - 1);
   assign acc_step   = {mul_sum, acc[W-1:S]};
   assign hl_n       = neg_lo ? -acc_step : acc_step;
`endif
   always_comb begin
      state_n = state;
      busy    = 1'b0;
      done    = 1'b0;
      if (state == MD_IDLE) begin
         busy    = start;
         state_n = start && !flush ? MD_BUSY : MD_IDLE;
      end else begin
         busy    = 1'b1;
         done    = count == last_count && !flush;
         state_n = flush || done ? MD_IDLE : MD_BUSY;
      end
   end
   always_ff @(posedge CLK or negedge nRST)
      if (!nRST) begin
         state  <= MD_IDLE;
         count  <= '0;
         acc    <= '0;
         dvs    <= '0;
         neg_lo <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         state <= state_n;
         count <= state == MD_IDLE ? '0 : count + 1'b1;
         acc   <= state == MD_IDLE ? acc_ld : acc_step;
         if (state == MD_IDLE) begin
            dvs    <= dvs_ld;
            neg_lo <= sgn && (a[W-1] ^ b[W-1]);
         end
         if (done) {hi, lo} <= hl_n;
      end
endmodule

// File: rtl/execute_muldiv.sv
// execute_muldiv: ID/EX latch, ALU with operand select, and multiply/divide with HI/LO and stall.
// Define EX_DIV_EN to build the divider; without it DIV/DIVU behave as MD_NONE.
module execute_muldiv import cpu_types_pkg::*; #(
   parameter int WIDTH         = 32,
   parameter int MUL_STEP_BITS = 1,
   parameter int REG_AW        = 5
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              flush,
   input  logic              exen,
   input  logic [3:0]        ALUOp,
   input  logic [1:0]        ALUSrc,
   input  logic [2:0]        mdOp,
   input  logic [WIDTH-1:0]  rdat1,
   input  logic [WIDTH-1:0]  rdat2,
   input  logic [WIDTH-1:0]  imm,
   input  logic [WIDTH-1:0]  shamt,
   input  logic              regWr,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic              halt,
   input  logic [REG_AW-1:0] regDst,
   output logic [WIDTH-1:0]  ALUOut_next,
   output logic [WIDTH-1:0]  dmemstore_next,
   output logic              regWr_next,
   output logic              dREN_next,
   output logic              dWEN_next,
   output logic              halt_next,
   output logic [REG_AW-1:0] regDst_next,
   output logic              equal,
   output logic              md_busy
);
   localparam int SW = $clog2(WIDTH);
   typedef struct packed {
      logic              valid;
      aluop_t            aluop;
      logic [1:0]        alusrc;
      md_op_t            mdop;
      logic [WIDTH-1:0]  rdat1;
      logic [WIDTH-1:0]  rdat2;
      logic [WIDTH-1:0]  imm;
      logic [WIDTH-1:0]  shamt;
      logic              regwr;
      logic              dren;
      logic              dwen;
      logic              halt;
      logic [REG_AW-1:0] regdst;
   } idex_t;
   idex_t q;
   logic [WIDTH-1:0] portb, alu, hi, lo;
   logic md_done;
   // a finished MD op stays in the latch as a bubble until the next capture
   always_ff @(posedge CLK or negedge nRST)
      if (!nRST) q <= '0;
      else if (flush) q <= '0;
      else if (md_busy) begin
         if (md_done) begin
            q.mdop  <= MD_NONE;
            q.regwr <= 1'b0;
         end
      end else if (exen) q <= '{1'b1, aluop_t'(ALUOp), ALUSrc, md_op_t'(mdOp), rdat1, rdat2,
                                imm, shamt, regWr, dREN, dWEN, halt, regDst};
   assign portb = q.alusrc == 2'd0 ? q.rdat2 : q.alusrc == 2'd1 ? q.imm :
                  q.alusrc == 2'd2 ? q.shamt : '0;
   always_comb begin
      alu = '0;
      case (q.aluop)
         ALU_SLL:  alu = q.rdat1 << portb[SW-1:0];
         ALU_SRL:  alu = q.rdat1 >> portb[SW-1:0];
         ALU_SRA:  alu = $signed(q.rdat1) >>> portb[SW-1:0];
         ALU_ADD:  alu = q.rdat1 + portb;
         ALU_SUB:  alu = q.rdat1 - portb;
         ALU_AND:  alu = q.rdat1 & portb;
         ALU_OR:   alu = q.rdat1 | portb;
         ALU_XOR:  alu = q.rdat1 ^ portb;
         ALU_NOR:  alu = ~(q.rdat1 | portb);
         ALU_SLT:  alu = WIDTH'($signed(q.rdat1) < $signed(portb));
         ALU_SLTU: alu = WIDTH'(q.rdat1 < portb);
         default:  alu = '0;
      endcase
   end
   muldiv_unit #(.WIDTH(WIDTH), .MUL_STEP_BITS(MUL_STEP_BITS)) u_md (
      .CLK(CLK), .nRST(nRST), .flush(flush), .op(q.mdop), .a(q.rdat1), .b(q.rdat2),
      .hi(hi), .lo(lo), .busy(md_busy), .done(md_done)
   );
   assign ALUOut_next    = q.mdop == MFHI ? hi : q.mdop == MFLO ? lo : alu;
   assign equal          = q.valid && alu == '0;
   assign dmemstore_next = q.rdat2;
   assign regWr_next     = q.regwr && !(q.mdop inside {MULT, MULTU, DIV, DIVU});
   assign dREN_next      = q.dren;
   assign dWEN_next      = q.dwen;
   assign halt_next      = q.halt;
   assign regDst_next    = q.regdst;
endmodule
